// File: rtl/led_ctrl.sv
// led_ctrl: per-channel button-driven LED controller.
//   Each active-low button is synchronized, debounced and turned into a single
//   press pulse. Each press steps that channel's mode OFF -> ON -> BLINK -> PWM -> OFF.
//   BLINK LEDs follow a shared blink phase, and PWM LEDs follow a shared 8-bit PWM
//   counter compared against a latched duty value.
//
// Build option:
//   LED_CTRL_PWM_EN  When defined, the PWM mode and its counter/duty latch are
//                    built. When undefined, the mode sequence is 0 -> 1 -> 2 -> 0,
//                    and duty is ignored.
//
// Ports:
//   main_clk  system clock, rising edge
//   rst       synchronous, active-low reset
//   n_button  raw asynchronous buttons, active-low, one per channel
//   duty      shared PWM duty value
//   n_led     registered LED drives, active-low
//   mode_o    per-channel mode; channel i is at bits [2i+1:2i]
//   press_o   one-cycle debounced press pulse per channel
module led_ctrl #(
  parameter int unsigned NUM_LED     = 4,
  parameter int unsigned DB_CYCLES   = 16,
  parameter int unsigned BLINK_DIV_W = 24
) (
  input  logic                   main_clk,
  input  logic                   rst,
  input  logic [NUM_LED-1:0]     n_button,
  input  logic [7:0]             duty,
  output logic [NUM_LED-1:0]     n_led,
  output logic [2*NUM_LED-1:0]   mode_o,
  output logic [NUM_LED-1:0]     press_o
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  logic [NUM_LED-1:0]     sync1;
  logic [NUM_LED-1:0]     sync2;
  logic [NUM_LED-1:0]     deb;
  logic [CNT_W-1:0]       db_cnt [NUM_LED];
  mode_e                  mode   [NUM_LED];
  logic [BLINK_DIV_W-1:0] blink_div;
  logic                   blink_phase;
  logic                   pwm_lit_c;

  // Next mode for a channel; the wrap point depends on whether PWM is built
  function automatic mode_e next_mode(input mode_e m);
    mode_e n;
    n = MODE_OFF;
    case (m)
      MODE_OFF:   n = MODE_ON;
      MODE_ON:    n = MODE_BLINK;
`ifdef LED_CTRL_PWM_EN
      MODE_BLINK: n = MODE_PWM;
`else
      MODE_BLINK: n = MODE_OFF;
`endif
      default:    n = MODE_OFF;
    endcase
    return n;
  endfunction

  // Two-flop synchronizer on the inverted (active-high) buttons
  always_ff @(posedge main_clk) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~n_button;
      sync2 <= sync1;
    end
  end

  // Debounce: the synced level must differ for DB_CYCLES consecutive cycles.
  // The press pulse is raised on the same edge that the debounced level rises.
  always_ff @(posedge main_clk) begin
    if (!rst) begin
      deb     <= '0;
      press_o <= '0;
      for (int i = 0; i < int'(NUM_LED); i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      press_o <= '0;
      for (int i = 0; i < int'(NUM_LED); i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_MAX) begin
          deb[i]     <= sync2[i];
          db_cnt[i]  <= '0;
          press_o[i] <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Per-channel mode stepping on a press pulse
  always_ff @(posedge main_clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(NUM_LED); i++) begin
        mode[i] <= MODE_OFF;
      end
    end else begin
      for (int i = 0; i < int'(NUM_LED); i++) begin
        if (press_o[i]) begin
          mode[i] <= next_mode(mode[i]);
        end
      end
    end
  end

  for (genvar g = 0; g < int'(NUM_LED); g++) begin : g_mode_o
    assign mode_o[2*g +: 2] = mode[g];
  end

  // Free-running blink prescaler; the phase flips on every wrap
  always_ff @(posedge main_clk) begin
    if (!rst) begin
      blink_div   <= '0;
      blink_phase <= 1'b0;
    end else begin
      blink_div <= blink_div + BLINK_DIV_W'(1);
      if (&blink_div) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

`ifdef LED_CTRL_PWM_EN
  logic [7:0] pwm_cnt;
  logic [7:0] duty_q;

  // PWM counter and duty latch; the duty only changes at counter 0
  always_ff @(posedge main_clk) begin
    if (!rst) begin
      pwm_cnt <= '0;
      duty_q  <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'd0) begin
        duty_q <= duty;
      end
    end
  end

  // At counter 0 the value being latched is already the one in force
  always_comb begin
    pwm_lit_c = 1'b0;
    if (pwm_cnt == 8'd0) begin
      pwm_lit_c = (pwm_cnt < duty);
    end else begin
      pwm_lit_c = (pwm_cnt < duty_q);
    end
  end
`else
  logic unused_duty;
  assign unused_duty = ^duty;
  assign pwm_lit_c   = 1'b0;
`endif

  // Registered active-low LED drive
  always_ff @(posedge main_clk) begin
    if (!rst) begin
      n_led <= '1;
    end else begin
      for (int i = 0; i < int'(NUM_LED); i++) begin
        case (mode[i])
          MODE_OFF:   n_led[i] <= 1'b1;
          MODE_ON:    n_led[i] <= 1'b0;
          MODE_BLINK: n_led[i] <= ~blink_phase;
          MODE_PWM:   n_led[i] <= ~pwm_lit_c;
          default:    n_led[i] <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed self-checking bench for led_ctrl
// (NUM_LED=4, DB_CYCLES=4, BLINK_DIV_W=4).
// Expectations for the PWM channel follow whether LED_CTRL_PWM_EN is defined.
module tb_led_ctrl;

  localparam int unsigned NUM_LED     = 4;
  localparam int unsigned DB_CYCLES   = 4;
  localparam int unsigned BLINK_DIV_W = 4;

  logic                 main_clk = 1'b0;
  logic                 rst;
  logic [NUM_LED-1:0]   n_button;
  logic [7:0]           duty;
  logic [NUM_LED-1:0]   n_led;
  logic [2*NUM_LED-1:0] mode_o;
  logic [NUM_LED-1:0]   press_o;

  int checks = 0;
  int errors = 0;

  always #5 main_clk = ~main_clk;

  led_ctrl #(
    .NUM_LED    (NUM_LED),
    .DB_CYCLES  (DB_CYCLES),
    .BLINK_DIV_W(BLINK_DIV_W)
  ) dut (
    .main_clk(main_clk),
    .rst     (rst),
    .n_button(n_button),
    .duty    (duty),
    .n_led   (n_led),
    .mode_o  (mode_o),
    .press_o (press_o)
  );

  task automatic tick();
    @(posedge main_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Hold a button for 8 cycles, release for 8, and expect exactly one pulse
  task automatic press(input int ch);
    int pulses;
    pulses = 0;
    n_button[ch] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) n_button[ch] = 1'b1;
      tick();
      if (press_o[ch]) pulses++;
    end
    chk("press_once", 32'(pulses), 32'd1);
  endtask

  initial begin
    int lo;
    int hi;
    int found;
    logic prev;

    // Reset
    rst      = 1'b0;
    n_button = '1;
    duty     = 8'd64;
    repeat (3) tick();
    chk("rst_n_led", 32'(n_led), 32'hF);
    chk("rst_mode", 32'(mode_o), 32'h0);
    chk("rst_press", 32'(press_o), 32'h0);
    rst = 1'b1;

    // Idle
    for (int k = 0; k < 50; k++) begin
      tick();
      chk("idle_n_led", 32'(n_led), 32'hF);
      chk("idle_mode", 32'(mode_o), 32'h0);
      chk("idle_press", 32'(press_o), 32'h0);
    end

    // A single held button gives a single press 6 cycles later
    n_button[0] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("b0_press", 32'(press_o), (k == 6) ? 32'h1 : 32'h0);
      if (k == 6) chk("b0_mode_pre", 32'(mode_o), 32'h0);
      if (k == 7) begin
        chk("b0_mode", 32'(mode_o), 32'h01);
        chk("b0_nled_pre", 32'(n_led), 32'hF);
      end
      if (k == 8) chk("b0_nled", 32'(n_led), 32'hE);
    end
    n_button[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("b0_release_press", 32'(press_o), 32'h0);
    end
    chk("b0_mode_hold", 32'(mode_o), 32'h01);
    chk("b0_nled_hold", 32'(n_led), 32'hE);

    // Bouncing button 1 never debounces
    for (int k = 0; k < 20; k++) begin
      n_button[1] = ((k / 2) % 2 == 1);
      tick();
      chk("b1_bounce_press", 32'(press_o), 32'h0);
    end
    n_button[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b1_settle_press", 32'(press_o), 32'h0);
    end
    chk("b1_mode", 32'(mode_o), 32'h01);

    // Blink: channel 2 into mode 2, then 16 low / 16 high
    press(2);
    press(2);
    chk("b2_mode", 32'(mode_o), 32'h21);
    found = 0;
    prev  = n_led[2];
    for (int k = 0; k < 64; k++) begin
      tick();
      if (prev == 1'b1 && n_led[2] == 1'b0) begin
        found = 1;
        break;
      end
      prev = n_led[2];
    end
    chk("blink_fall_found", 32'(found), 32'd1);
    lo = 1;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (n_led[2] == 1'b0) lo++;
      else break;
    end
    hi = 1;
    for (int k = 0; k < 64; k++) begin
      tick();
      if (n_led[2] == 1'b1) hi++;
      else break;
    end
    chk("blink_low_len", 32'(lo), 32'd16);
    chk("blink_high_len", 32'(hi), 32'd16);

    // PWM: channel 3 pressed three times
    press(3);
    press(3);
    press(3);
`ifdef LED_CTRL_PWM_EN
    chk("b3_mode", 32'(mode_o), 32'hE1);
    lo = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      if (n_led[3] == 1'b0) lo++;
    end
    chk("pwm64_low_count", 32'(lo), 32'd64);
    // Change the duty right after the lit part of a period has ended
    found = 0;
    prev  = n_led[3];
    for (int k = 0; k < 300; k++) begin
      tick();
      if (prev == 1'b0 && n_led[3] == 1'b1) begin
        found = 1;
        break;
      end
      prev = n_led[3];
    end
    chk("pwm_rise_found", 32'(found), 32'd1);
    duty = 8'd128;
    lo = 0;
    for (int k = 0; k < 150; k++) begin
      tick();
      if (n_led[3] == 1'b0) lo++;
    end
    chk("pwm_midperiod_low", 32'(lo), 32'd0);
    found = 0;
    prev  = n_led[3];
    for (int k = 0; k < 300; k++) begin
      tick();
      if (prev == 1'b1 && n_led[3] == 1'b0) begin
        found = 1;
        break;
      end
      prev = n_led[3];
    end
    chk("pwm_fall_found", 32'(found), 32'd1);
    lo = 1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (n_led[3] == 1'b0) lo++;
      else break;
    end
    hi = 1;
    for (int k = 0; k < 300; k++) begin
      tick();
      if (n_led[3] == 1'b1) hi++;
      else break;
    end
    chk("pwm128_low_len", 32'(lo), 32'd128);
    chk("pwm128_high_len", 32'(hi), 32'd128);
`else
    chk("b3_mode_wrap", 32'(mode_o), 32'h21);
    chk("b3_nled_off", 32'(n_led[3]), 32'd1);
`endif

    // Simultaneous presses on channels 0 and 1
    n_button[1:0] = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("b01_press", 32'(press_o), (k == 6) ? 32'h3 : 32'h0);
      if (k == 7) chk("b01_mode", 32'(mode_o[3:0]), 32'h6);
    end
    n_button[1:0] = 2'b11;
    repeat (8) tick();

    // Reset in the middle of a press of button 2, with the button still held
    n_button[2] = 1'b0;
    repeat (4) tick();
    rst = 1'b0;
    tick();
    tick();
    chk("rst2_mode", 32'(mode_o), 32'h0);
    chk("rst2_press", 32'(press_o), 32'h0);
    chk("rst2_n_led", 32'(n_led), 32'hF);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("b2_held_press", 32'(press_o), (k == 6) ? 32'h4 : 32'h0);
      if (k == 7) chk("b2_held_mode", 32'(mode_o), 32'h10);
    end
    n_button[2] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("b2_release_press", 32'(press_o), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
